// File: rtl/draw_scheduler.sv
// draw_scheduler: sequences entity slots through per-class sprite drawers onto one framebuffer port
//
// On frame_start (IDLE) the entity table and slot classes are snapshotted. Each slot is
// then scanned in order. Inactive slots and slots with an out-of-range class are skipped.
// Every other slot is handed to its class drawer with a one-cycle start pulse, and
// that drawer's pixel stream is routed to the framebuffer port until it signals done.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   frame_start       one-cycle frame request (ignored unless idle)
//   entities          packed entity table, slot i at [i*ENTITY_SIZE +: ENTITY_SIZE]
//   slot_class        packed drawer class per slot
//   d_start           one-hot start pulse to the drawers
//   d_entity          entity word for the current drawer (registered)
//   d_x/d_y/d_color/d_plot/d_done   per-drawer pixel stream and done
//   x/y/color/plot    muxed pixel stream, zero outside WAIT
//   busy              high whenever not IDLE
//   frame_done        one-cycle end-of-frame pulse
//   drawn_count       entities drawn in the last completed frame
//   timeout_err       sticky watchdog flag
//
// Optional feature: define DRAW_SCHED_TIMEOUT_EN to build a WAIT watchdog of
// TIMEOUT_CYCLES. Without it, timeout_err reads 0 and WAIT waits indefinitely.
module draw_scheduler #(
   parameter int ENTITY_SIZE    = 34,
   parameter int NUM_CLASSES    = 3,
   parameter int MAX_SLOTS      = 16,
   parameter int CLS_W          = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   parameter int COORD_W        = 10,
   parameter int COLOR_W        = 3,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               frame_start,
   input  logic [MAX_SLOTS*ENTITY_SIZE-1:0]   entities,
   input  logic [MAX_SLOTS*CLS_W-1:0]         slot_class,
   output logic [NUM_CLASSES-1:0]             d_start,
   output logic [ENTITY_SIZE-1:0]             d_entity,
   input  logic [NUM_CLASSES*COORD_W-1:0]     d_x,
   input  logic [NUM_CLASSES*COORD_W-1:0]     d_y,
   input  logic [NUM_CLASSES*COLOR_W-1:0]     d_color,
   input  logic [NUM_CLASSES-1:0]             d_plot,
   input  logic [NUM_CLASSES-1:0]             d_done,
   output logic [COORD_W-1:0]                 x,
   output logic [COORD_W-1:0]                 y,
   output logic [COLOR_W-1:0]                 color,
   output logic                               plot,
   output logic                               busy,
   output logic                               frame_done,
   output logic [$clog2(MAX_SLOTS+1)-1:0]     drawn_count,
   output logic                               timeout_err
);
   localparam int IDX_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
   localparam int CNT_W = $clog2(MAX_SLOTS+1);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_SLOTS-1);
   localparam logic [CLS_W:0]   NCLS = (CLS_W+1)'(NUM_CLASSES);

   typedef enum logic [2:0] {IDLE, SCAN, START, WAIT, FDONE} state_t;
   state_t state, state_nx;

   logic [MAX_SLOTS*ENTITY_SIZE-1:0] snap_ent;
   logic [MAX_SLOTS*CLS_W-1:0]       snap_cls;
   logic [IDX_W-1:0]                 idx;
   logic [CNT_W-1:0]                 count;
   logic [CLS_W-1:0]                 cls;
   logic [ENTITY_SIZE-1:0]           cur_ent;
   logic [CLS_W-1:0]                 cur_cls;
   logic                             cur_ok, last, done_hit, expire, adv;
   logic [COORD_W-1:0]               dx [NUM_CLASSES];
   logic [COORD_W-1:0]               dy [NUM_CLASSES];
   logic [COLOR_W-1:0]               dc [NUM_CLASSES];

   for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_unpack
      assign dx[i] = d_x[i*COORD_W +: COORD_W];
      assign dy[i] = d_y[i*COORD_W +: COORD_W];
      assign dc[i] = d_color[i*COLOR_W +: COLOR_W];
   end

   // A slot is drawable only if its active bit is set and its class names a real drawer.
   assign cur_ent  = snap_ent[idx*ENTITY_SIZE +: ENTITY_SIZE];
   assign cur_cls  = snap_cls[idx*CLS_W +: CLS_W];
   assign cur_ok   = cur_ent[ENTITY_SIZE-1] && ({1'b0, cur_cls} < NCLS);
   assign last     = idx == LAST;
   assign done_hit = (state == WAIT) && d_done[cls];
   assign adv      = done_hit || expire;

`ifdef DRAW_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
   logic [WD_W-1:0] wd;
   logic            t_err;
   // wd is zero on the first WAIT cycle, so expiry lands on the TIMEOUT_CYCLES-th WAIT cycle.
   assign expire      = (state == WAIT) && !d_done[cls] && (wd == WD_W'(TIMEOUT_CYCLES-1));
   assign timeout_err = t_err;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wd    <= '0;
         t_err <= 1'b0;
      end else begin
         wd <= (state == WAIT) ? wd + 1'b1 : '0;
         if (expire) t_err <= 1'b1;
      end
   end
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         snap_ent    <= '0;
         snap_cls    <= '0;
         idx         <= '0;
         count       <= '0;
         cls         <= '0;
         d_entity    <= '0;
         drawn_count <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && frame_start) begin
            snap_ent <= entities;
            snap_cls <= slot_class;
            idx      <= '0;
            count    <= '0;
         end
         if (state == SCAN && cur_ok) begin
            d_entity <= cur_ent;
            cls      <= cur_cls;
         end
         if (((state == SCAN && !cur_ok) || adv) && !last) idx <= idx + 1'b1;
         if (done_hit) count <= count + 1'b1;
         if (state == FDONE) drawn_count <= count;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = frame_start ? SCAN : IDLE;
         SCAN:    state_nx = cur_ok ? START : (last ? FDONE : SCAN);
         START:   state_nx = WAIT;
         WAIT:    state_nx = adv ? (last ? FDONE : SCAN) : WAIT;
         FDONE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      d_start    = (state == START) ? (NUM_CLASSES'(1) << cls) : '0;
      x          = (state == WAIT) ? dx[cls] : '0;
      y          = (state == WAIT) ? dy[cls] : '0;
      color      = (state == WAIT) ? dc[cls] : '0;
      plot       = (state == WAIT) && d_plot[cls];
      busy       = state != IDLE;
      frame_done = state == FDONE;
   end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: randomized self-checking bench for draw_scheduler against a frame timeline model
module tb_draw_scheduler;
   localparam int MS = 4;
   localparam int NC = 3;
   localparam int CW = 2;
   localparam int ES = 34;
   localparam int CO = 10;
   localparam int CL = 3;
   localparam int TL = 128;

   logic              clk = 1'b0;
   logic              reset_n, frame_start;
   logic [MS*ES-1:0]  entities;
   logic [MS*CW-1:0]  slot_class;
   logic [NC-1:0]     d_start;
   logic [ES-1:0]     d_entity;
   logic [NC*CO-1:0]  d_x, d_y;
   logic [NC*CL-1:0]  d_color;
   logic [NC-1:0]     d_plot, d_done;
   logic [CO-1:0]     x, y;
   logic [CL-1:0]     color;
   logic              plot, busy, frame_done, timeout_err;
   logic [2:0]        drawn_count;

   int checks = 0;
   int failures = 0;

   logic [ES-1:0] fe [MS];
   int            fc [MS];
   int            fdl [MS];

   draw_scheduler #(.MAX_SLOTS(MS)) dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
      .entities(entities), .slot_class(slot_class),
      .d_start(d_start), .d_entity(d_entity),
      .d_x(d_x), .d_y(d_y), .d_color(d_color), .d_plot(d_plot), .d_done(d_done),
      .x(x), .y(y), .color(color), .plot(plot),
      .busy(busy), .frame_done(frame_done), .drawn_count(drawn_count),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_inputs(input bit noisy_table);
      logic [63:0] r;
      d_x     = {$urandom, $urandom};
      d_y     = {$urandom, $urandom};
      d_color = NC*CL'($urandom);
      d_plot  = NC'($urandom);
      d_done  = NC'($urandom);
      if (noisy_table)
         for (int i = 0; i < MS; i++) begin
            r = {$urandom, $urandom};
            entities[i*ES +: ES] = r[ES-1:0];
            slot_class[i*CW +: CW] = CW'($urandom);
         end
   endtask

   // Expected per-cycle behaviour is derived from the latency rules: relative to the
   // request cycle 0, slots are visited from cycle 1; an inactive slot costs one cycle,
   // an active one costs scan + start + its drawer's wait cycles, then one end cycle.
   task automatic run_frame(input bit noise, input int abort_at);
      logic [NC-1:0] st [TL];
      int            wc [TL];
      logic [ES-1:0] we [TL];
      bit            dn [TL];
      int            c, fd, cnt, n;
      for (int k = 0; k < TL; k++) begin
         st[k] = '0; wc[k] = -1; we[k] = '0; dn[k] = 1'b0;
      end
      c = 1; cnt = 0;
      for (int i = 0; i < MS; i++) begin
         if (fe[i][ES-1] && fc[i] < NC) begin
            n = fdl[i];
            st[c+1] = NC'(1) << fc[i];
            we[c+1] = fe[i];
            for (int k = 1; k <= n; k++) begin
               wc[c+1+k] = fc[i];
               we[c+1+k] = fe[i];
            end
            dn[c+1+n] = 1'b1;
            c += 2 + n;
            cnt++;
         end else c += 1;
      end
      fd = c;
      for (int rc = 0; rc <= fd + 1; rc++) begin
         @(negedge clk);
         rand_inputs(noise && rc > 0);
         if (rc == 0)
            for (int i = 0; i < MS; i++) begin
               entities[i*ES +: ES] = fe[i];
               slot_class[i*CW +: CW] = CW'(fc[i]);
            end
         frame_start = (rc == 0) ? 1'b1 : (noise && rc <= fd) ? 1'($urandom) : 1'b0;
         if (wc[rc] >= 0) d_done[wc[rc]] = dn[rc];
         if (rc == abort_at) reset_n = 1'b0;
         #1;
         chk("d_start", d_start, st[rc]);
         chk("busy", busy, rc >= 1 && rc <= fd);
         chk("frame_done", frame_done, rc == fd);
         chk("timeout_err", timeout_err, 0);
         if (wc[rc] >= 0) begin
            chk("x", x, d_x[wc[rc]*CO +: CO]);
            chk("y", y, d_y[wc[rc]*CO +: CO]);
            chk("color", color, d_color[wc[rc]*CL +: CL]);
            chk("plot", plot, d_plot[wc[rc]]);
         end else begin
            chk("x_idle", x, 0);
            chk("y_idle", y, 0);
            chk("color_idle", color, 0);
            chk("plot_idle", plot, 0);
         end
         if (st[rc] != 0 || wc[rc] >= 0) chk("d_entity", d_entity, we[rc]);
         if (rc == fd + 1) chk("drawn_count", drawn_count, cnt);
         if (rc == abort_at) break;
      end
      if (abort_at >= 0) begin
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            reset_n = 1'b1;
            frame_start = 1'b0;
            rand_inputs(1'b0);
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_plot", plot, 0);
            chk("rst_d_start", d_start, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_drawn_count", drawn_count, 0);
         end
      end
   endtask

   task automatic clear_table();
      for (int i = 0; i < MS; i++) begin
         fe[i] = '0; fc[i] = 0; fdl[i] = 1;
      end
   endtask

   initial begin
      logic [63:0] r;
      reset_n = 1'b0; frame_start = 1'b0;
      entities = '0; slot_class = '0;
      d_x = '0; d_y = '0; d_color = '0; d_plot = '0; d_done = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_d_start", d_start, 0);
      chk("reset_plot", plot, 0);
      chk("reset_x", x, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_drawn_count", drawn_count, 0);
      chk("reset_timeout_err", timeout_err, 0);
      reset_n = 1'b1;

      clear_table();
      run_frame(1'b0, -1);

      clear_table();
      fe[0] = {1'b1, 33'h0_0123_4567}; fc[0] = 1; fdl[0] = 10;
      fe[2] = {1'b1, 33'h1_2345_6789}; fc[2] = 0; fdl[2] = 10;
      run_frame(1'b1, -1);

      clear_table();
      fe[1] = {1'b1, 33'h0_0abc_def0}; fc[1] = 3;
      run_frame(1'b0, -1);

      clear_table();
      fe[3] = {1'b1, 33'h0_0000_0fff}; fc[3] = 2; fdl[3] = 1;
      run_frame(1'b1, -1);

      clear_table();
      fe[0] = {1'b1, 33'h1_1111_1111}; fc[0] = 2; fdl[0] = 20;
      run_frame(1'b1, 5);

      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < MS; i++) begin
            r = {$urandom, $urandom};
            fe[i] = r[ES-1:0];
            fe[i][ES-1] = ($urandom % 4) != 0;
            fc[i] = $urandom % 4;
            fdl[i] = $urandom_range(1, 12);
         end
         run_frame(1'b1, (f % 10 == 9) ? $urandom_range(1, 8) : -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
